// File: rtl/dmem_pkg.sv
// Shared types and constants for the sized data memory.
// Access-size encoding, controller states and byte-lane width.
package dmem_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic {
        CLEAR,
        RUN
    } dmem_state_e;

endpackage

// File: rtl/data_memory_sized_if.sv
// Request/response bus between the load/store unit (master) and the data memory (slave).
interface data_memory_sized_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store strobes/replicated data and
// load extraction with zero or sign extension (little-endian lanes).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off_lo,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wstrb,
    output logic [31:0] wword,
    output logic [31:0] ldata
);
    logic [31:0] shifted;

    always_comb begin
        wstrb = '0;
        wword = '0;
        case (mem_size_e'(size))
            SZ_BYTE: begin
                wstrb = 4'b0001 << off_lo;
                wword = {4{wdata[BYTE_W-1:0]}};
            end
            SZ_HALF: begin
                wstrb = off_lo[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                wstrb = 4'b1111;
                wword = wdata;
            end
            default: ;
        endcase
    end

    // Move the addressed lane down to bit 0 before extending.
    assign shifted = rword >> {off_lo, 3'b000};

    always_comb begin
        ldata = '0;
        case (mem_size_e'(size))
            SZ_BYTE: ldata = {{24{sign & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ldata = {{16{sign & shifted[15]}}, shifted[15:0]};
            SZ_WORD: ldata = rword;
            default: ;
        endcase
    end
endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed single-port data memory with sized loads/stores, fault flagging
// and post-reset clear. Define DMEM_ACCESS_CNT_EN to add load/store/fault counters.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DEPTH_WORDS = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_sized_if.slave bus,
    output logic               busy
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]        ld_count,
    output logic [31:0]        st_count,
    output logic [31:0]        fault_count
`endif
);
    localparam int unsigned       IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0]   SPAN  = (ADDR_W + 1)'(4 * DEPTH_WORDS);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DEPTH_WORDS - 1);

    dmem_state_e       state;
    logic [IDX_W-1:0]  clr_idx;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  widx;
    logic              fault;
    logic              accept;
    logic [3:0]        wstrb;
    logic [31:0]       wword;
    logic [31:0]       ldata;

    assign off  = bus.req_addr - BASE_ADDR;
    assign widx = off[IDX_W+1:2];

    always_comb begin
        fault = 1'b0;
        case (mem_size_e'(bus.req_size))
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = off[0];
            SZ_WORD: fault = |off[1:0];
            default: fault = 1'b1;
        endcase
        if (bus.req_addr < BASE_ADDR || {1'b0, off} >= SPAN) begin
            fault = 1'b1;
        end
    end

    assign bus.req_ready = (state == RUN) && (!bus.rsp_valid || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    dmem_lane_align u_align (
        .size   (bus.req_size),
        .off_lo (off[1:0]),
        .sign   (bus.req_signed),
        .wdata  (bus.req_wdata),
        .rword  (mem[widx]),
        .wstrb  (wstrb),
        .wword  (wword),
        .ldata  (ldata)
    );

    // Array has no reset; the CLEAR sweep zeroes it after every reset release.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (accept && bus.req_write && !fault) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[widx][b*BYTE_W +: BYTE_W] <= wword[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CLEAR;
            clr_idx       <= '0;
            busy          <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_fault <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= (bus.req_write || fault) ? '0 : ldata;
                        bus.rsp_fault <= fault;
                    end else if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_count    <= '0;
            st_count    <= '0;
            fault_count <= '0;
        end else if (accept) begin
            if (bus.req_write) st_count <= st_count + 1'b1;
            else               ld_count <= ld_count + 1'b1;
            if (fault)         fault_count <= fault_count + 1'b1;
        end
    end
`endif
endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor to the core's word-only data memory.
- Single-port, byte-addressed, little-endian memory with byte, halfword and word loads/stores and optional sign extension.
- Valid/ready request and response handshake, registered read data, and a self-clearing init sequence after reset.
- Sits between the datapath load/store unit and the memory map; flags misaligned and out-of-range accesses instead of aliasing them.

Parameters:
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 64, number of 32-bit words; power of two, >= 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend byte/half loads; ignored for stores and words.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  load result, right-aligned and extended; 0 for stores and faults.
- rsp_fault  out  1  access was misaligned, out of range or illegal size.
- busy  out  1  init clear in progress.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=CLEAR, clear index=0.
  - rsp_valid=0, rsp_rdata=0, rsp_fault=0, req_ready=0, busy=1.
- FSM states CLEAR and RUN:
  - CLEAR: writes 0 to word[index] each cycle. After writing word DEPTH_WORDS-1 it moves to RUN, so busy is high for exactly DEPTH_WORDS cycles after reset release.
  - RUN: busy=0. No return to CLEAR except via reset.
- req_ready = (state==RUN) && (!rsp_valid || rsp_ready). This is a one-entry response buffer, and back-to-back accepts are allowed when rsp_ready=1.
- Offset calculation: off = req_addr - BASE_ADDR, computed at ADDR_W bits. Word index = off[log2(DEPTH_WORDS)+1:2].
- Fault conditions, any of:
  - req_size==11;
  - half with off[0]=1;
  - word with off[1:0]!=0;
  - req_addr < BASE_ADDR;
  - off >= 4*DEPTH_WORDS.
- Store on accept:
  - Only the addressed byte lanes are written at that edge: byte lane = off[1:0], half lanes = {off[1],0}/{off[1],1}.
  - Other lanes are unchanged.
  - A faulted store writes nothing.
  - Response next cycle: rsp_valid=1, rsp_rdata=0, rsp_fault=fault.
- Load on accept:
  - Lane selection happens at the accept edge, so rsp_rdata and rsp_valid appear next cycle (latency 1).
  - Byte/half results are zero-extended, or sign-extended when req_signed=1.
  - Faulted load: rsp_rdata=0, rsp_fault=1.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- Response hold: rsp_valid, rsp_rdata and rsp_fault stay stable until rsp_ready. rsp_valid drops the cycle after the handshake unless a new request is accepted in the same cycle.
- Reset mid-operation aborts any pending response, discards it, and restarts CLEAR.
- Requests during CLEAR are not accepted; the requester must hold req_valid.

Optional Feature:
- Macro: DMEM_ACCESS_CNT_EN.
- Defined:
  - Adds outputs ld_count, st_count and fault_count, each 32 bits.
  - Each increments on accept of a load, a store, or a faulted access respectively. A faulted load counts in both ld_count and fault_count.
  - Counters wrap at 2^32, reset to 0 on rst_n, and do not count during CLEAR.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - mem_size_e enum: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - dmem_state_e: CLEAR, RUN;
  - byte-lane width constant 8.
- Sub-module dmem_lane_align, purely combinational:
  - store path: builds the 4-bit write strobe and lane-shifted write word from size, off[1:0] and wdata;
  - load path: extracts and extends the load result from the read word.
- Memory array, FSM and handshake stay in the top module.

Test Plan:
- Reset with DEPTH_WORDS=64:
  - busy is high for 64 cycles and req_ready stays 0 throughout;
  - afterwards, a word load at 0x0FC returns 0x0000_0000 with rsp_fault=0.
- Byte store then loads:
  - store byte 0xA5 at 0x011, then word load at 0x010 returns 0x0000_A500;
  - signed byte load at 0x011 returns 0xFFFF_FFA5; unsigned returns 0x0000_00A5.
- Half store then load:
  - store word 0x1122_3344 at 0x020, then half 0xBEEF at 0x022;
  - word load at 0x020 returns 0xBEEF_3344; signed half load at 0x022 returns 0xFFFF_BEEF.
- Faults:
  - word load at 0x002 gives rsp_fault=1, rsp_rdata=0;
  - store at 0x100 (out of range) gives rsp_fault=1, and a later word load at 0x000 is unchanged.
- Backpressure:
  - hold rsp_ready=0 after a load: req_ready=0 and response fields stay stable for 5 cycles;
  - raising rsp_ready with a new req_valid completes the response and accepts the next request in the same cycle.
- Reset mid-operation:
  - assert rst_n low while rsp_valid=1: rsp_valid drops immediately and busy returns to 1;
  - with DMEM_ACCESS_CNT_EN defined, all counters read 0.
